wb_slave_pipelined_mem: RTL and testbench

Parametrised pipelined Wishbone B4 slave with internal word memory. It supersedes the fixed pipelined slave. It adds the following:
- configurable response latency
- an outstanding-request limit with stall back-pressure
- byte selects
- out-of-range error responses
- optional periodic stall injection for bench stress

It sits on the shared if_wb bus opposite a pipelined master.

---
 rtl/wb_slave_pipelined_mem_if.sv | 27 ++
 rtl/wb_slave_pipelined_mem.sv | 168 ++++++++++++++++
 tb/tb_wb_slave_pipelined_mem.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_pipelined_mem_if.sv
// Pipelined Wishbone B4 bus bundle shared between a pipelined master and
// the memory slave. Signal names follow the Wishbone slave view.
interface wb_slave_pipelined_mem_if #(
    parameter int adr_width = 16,
    parameter int dat_width = 16
);
    logic [adr_width-1:0]   adr;
    logic [dat_width-1:0]   dat_i;
    logic [dat_width-1:0]   dat_o;
    logic [dat_width/8-1:0] sel;
    logic                   we;
    logic                   cyc;
    logic                   stb;
    logic                   ack;
    logic                   err;
    logic                   stall;

    modport master (
        output adr, dat_i, sel, we, cyc, stb,
        input  dat_o, ack, err, stall
    );

    modport slave (
        input  adr, dat_i, sel, we, cyc, stb,
        output dat_o, ack, err, stall
    );
endinterface

// File: rtl/wb_slave_pipelined_mem.sv
// Pipelined Wishbone B4 slave with an internal word memory.
// Requests are accepted on cyc & stb & !stall, the memory is accessed at the
// acceptance edge, and the result travels down a (latency-1)-deep pipeline
// into the registered ack/err/dat_o stage. Dropping cyc flushes everything
// in flight; writes already accepted stay in memory.
module wb_slave_pipelined_mem #(
    parameter int adr_width       = 16,
    parameter int dat_width       = 16,
    parameter int depth           = 256,
    parameter int latency         = 2,
    parameter int max_outstanding = 2,
    parameter int stall_period    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    wb_slave_pipelined_mem_if.slave bus
);
    localparam int NB       = dat_width / 8;
    localparam int IDX_W    = (depth > 1) ? $clog2(depth) : 1;
    localparam int OC_W     = $clog2(max_outstanding + 1);
    localparam int IC_W     = (stall_period > 1) ? $clog2(stall_period) : 1;
    localparam int INJ_LAST = (stall_period > 0) ? (stall_period - 1) : 0;

    logic [dat_width-1:0] r_mem [depth];
    logic [OC_W-1:0]      r_outstanding;
    logic [IC_W-1:0]      r_inj_cnt;
    logic                 r_ack;
    logic                 r_err;
    logic [dat_width-1:0] r_dat_o;

    logic                 w_inject;
    logic                 w_stall;
    logic                 w_accept;
    logic                 w_oor;
    logic [IDX_W-1:0]     w_idx;
    logic [dat_width-1:0] w_rdata;

    // Head of the response pipeline: the entry that turns into ack/err next edge.
    logic                 w_head_vld;
    logic                 w_head_oor;
    logic                 w_head_rd;
    logic [dat_width-1:0] w_head_dat;

    assign w_idx   = bus.adr[IDX_W-1:0];
    assign w_oor   = (32'(bus.adr) >= 32'(depth));
    assign w_rdata = r_mem[w_idx];

    // Stall is built purely from registered state so the master sees it early.
    always_comb begin
        w_inject = 1'b0;
        if ((stall_period != 0) && (r_inj_cnt == IC_W'(INJ_LAST))) begin
            w_inject = 1'b1;
        end else begin
            w_inject = 1'b0;
        end
        w_stall  = (r_outstanding == OC_W'(max_outstanding)) | w_inject;
        w_accept = bus.cyc & bus.stb & ~w_stall;
    end

    // Free-running stall-injection counter; parked at zero outside a bus cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inj_cnt <= {IC_W{1'b0}};
        end else if (!bus.cyc || (stall_period == 0)) begin
            r_inj_cnt <= {IC_W{1'b0}};
        end else if (r_inj_cnt == IC_W'(INJ_LAST)) begin
            r_inj_cnt <= {IC_W{1'b0}};
        end else begin
            r_inj_cnt <= r_inj_cnt + 1'b1;
        end
    end

    // Byte-lane write into memory at the acceptance edge; memory is never reset.
    always_ff @(posedge clk) begin
        if (w_accept && bus.we && !w_oor) begin
            for (int k = 0; k < NB; k++) begin
                if (bus.sel[k]) begin
                    r_mem[w_idx][k*8 +: 8] <= bus.dat_i[k*8 +: 8];
                end
            end
        end
    end

    generate
        if (latency == 1) begin : g_direct
            assign w_head_vld = w_accept;
            assign w_head_oor = w_oor;
            assign w_head_rd  = ~bus.we;
            assign w_head_dat = w_rdata;
        end else begin : g_pipe
            localparam int NS = latency - 1;
            logic                 r_vld [NS];
            logic                 r_oor [NS];
            logic                 r_rd  [NS];
            logic [dat_width-1:0] r_dat [NS];

            // Shift accepted requests toward the response stage; abort flushes validity.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < NS; i++) begin
                        r_vld[i] <= 1'b0;
                        r_oor[i] <= 1'b0;
                        r_rd[i]  <= 1'b0;
                        r_dat[i] <= {dat_width{1'b0}};
                    end
                end else if (!bus.cyc) begin
                    for (int i = 0; i < NS; i++) begin
                        r_vld[i] <= 1'b0;
                    end
                end else begin
                    r_vld[0] <= w_accept;
                    r_oor[0] <= w_oor;
                    r_rd[0]  <= ~bus.we;
                    r_dat[0] <= w_rdata;
                    for (int i = 1; i < NS; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_oor[i] <= r_oor[i-1];
                        r_rd[i]  <= r_rd[i-1];
                        r_dat[i] <= r_dat[i-1];
                    end
                end
            end

            assign w_head_vld = r_vld[NS-1];
            assign w_head_oor = r_oor[NS-1];
            assign w_head_rd  = r_rd[NS-1];
            assign w_head_dat = r_dat[NS-1];
        end
    endgenerate

    // Registered termination stage; read data is only updated on a read ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat_o <= {dat_width{1'b0}};
        end else if (!bus.cyc) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= w_head_vld & ~w_head_oor;
            r_err <= w_head_vld &  w_head_oor;
            if (w_head_vld && !w_head_oor && w_head_rd) begin
                r_dat_o <= w_head_dat;
            end
        end
    end

    // Requests accepted but whose response has not yet been launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= {OC_W{1'b0}};
        end else if (!bus.cyc) begin
            r_outstanding <= {OC_W{1'b0}};
        end else begin
            case ({w_accept, w_head_vld})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.dat_o = r_dat_o;
    assign bus.stall = w_stall;
endmodule

// File: tb/tb_wb_slave_pipelined_mem.sv
// Directed bench for wb_slave_pipelined_mem. Three instances with different
// parameter sets share one master driver; dsel picks which one is active.
module tb_wb_slave_pipelined_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] m_adr = 16'd0;
    logic [15:0] m_dat = 16'd0;
    logic [1:0]  m_sel = 2'b00;
    logic        m_we  = 1'b0;
    logic        m_cyc = 1'b0;
    logic        m_stb = 1'b0;
    int          dsel  = 0;

    logic        s_ack, s_err, s_stall;
    logic [15:0] s_dat;

    int checks = 0;
    int errors = 0;

    wb_slave_pipelined_mem_if #(.adr_width(16), .dat_width(16)) ifa ();
    wb_slave_pipelined_mem_if #(.adr_width(16), .dat_width(16)) ifb ();
    wb_slave_pipelined_mem_if #(.adr_width(16), .dat_width(16)) ifc ();

    assign ifa.adr = m_adr;  assign ifa.dat_i = m_dat;  assign ifa.sel = m_sel;
    assign ifa.we  = m_we;   assign ifa.stb   = m_stb;  assign ifa.cyc = m_cyc & (dsel == 0);
    assign ifb.adr = m_adr;  assign ifb.dat_i = m_dat;  assign ifb.sel = m_sel;
    assign ifb.we  = m_we;   assign ifb.stb   = m_stb;  assign ifb.cyc = m_cyc & (dsel == 1);
    assign ifc.adr = m_adr;  assign ifc.dat_i = m_dat;  assign ifc.sel = m_sel;
    assign ifc.we  = m_we;   assign ifc.stb   = m_stb;  assign ifc.cyc = m_cyc & (dsel == 2);

    wb_slave_pipelined_mem #(.latency(2), .max_outstanding(2), .stall_period(0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    wb_slave_pipelined_mem #(.latency(3), .max_outstanding(1), .stall_period(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    wb_slave_pipelined_mem #(.latency(2), .max_outstanding(2), .stall_period(4))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    // Observe the currently selected instance.
    always_comb begin
        case (dsel)
            1:       begin s_ack = ifb.ack; s_err = ifb.err; s_stall = ifb.stall; s_dat = ifb.dat_o; end
            2:       begin s_ack = ifc.ack; s_err = ifc.err; s_stall = ifc.stall; s_dat = ifc.dat_o; end
            default: begin s_ack = ifa.ack; s_err = ifa.err; s_stall = ifa.stall; s_dat = ifa.dat_o; end
        endcase
    end

    // Hard time limit in case something wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated request: wait out stall, get accepted, wait for termination.
    task automatic single(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] s, output int lat, output logic got_ack,
                          output logic got_err, output logic [15:0] rd);
        int n;
        m_cyc = 1'b1; m_we = w; m_adr = a; m_dat = d; m_sel = s; m_stb = 1'b1;
        n = 0;
        while (s_stall && n < 20) begin tick(); n++; end
        tick();
        m_stb = 1'b0;
        lat = 1;
        while (!(s_ack || s_err) && lat < 20) begin tick(); lat++; end
        got_ack = s_ack; got_err = s_err; rd = s_dat;
        tick();
        chk("pulse_one_cycle", {30'd0, s_ack, s_err}, 32'd0);
    endtask

    task automatic wr_chk(input string tag, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] s);
        int lat; logic ga, ge; logic [15:0] rd;
        single(1'b1, a, d, s, lat, ga, ge, rd);
        chk({tag, "_lat"}, lat, 32'd2);
        chk({tag, "_ackerr"}, {30'd0, ga, ge}, 32'd2);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp_d);
        int lat; logic ga, ge; logic [15:0] rd;
        single(1'b0, a, 16'd0, 2'b11, lat, ga, ge, rd);
        chk({tag, "_lat"}, lat, 32'd2);
        chk({tag, "_ackerr"}, {30'd0, ga, ge}, 32'd2);
        chk({tag, "_data"}, {16'd0, rd}, {16'd0, exp_d});
    endtask

    logic [15:0] rdq[$];
    int nack, nerr, nstall, ack_first, ack_last;

    // stb held high; the address advances only when a request is accepted.
    task automatic burst(input logic w, input logic [15:0] a0, input logic [15:0] d0, input int n);
        int idx, ci, extra;
        logic acc;
        nack = 0; nerr = 0; nstall = 0; ack_first = -1; ack_last = -1; rdq.delete();
        m_cyc = 1'b1; m_we = w; m_sel = 2'b11; idx = 0; ci = 0;
        while ((idx < n || (nack + nerr) < n) && ci < 200) begin
            if (idx < n) begin
                m_stb = 1'b1; m_adr = a0 + 16'(idx); m_dat = d0 + 16'(idx);
                acc = !s_stall;
                if (s_stall) nstall++;
            end else begin
                m_stb = 1'b0; acc = 1'b0;
            end
            tick();
            if (acc) idx++;
            if (s_ack || s_err) begin
                if (ack_first < 0) ack_first = ci;
                ack_last = ci;
                if (s_ack) begin nack++; rdq.push_back(s_dat); end
                else nerr++;
            end
            ci++;
        end
        m_stb = 1'b0;
        chk("burst_accepted", idx, n);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (s_ack || s_err) extra++;
        end
        chk("burst_no_extra_resp", extra, 32'd0);
    endtask

    int lat, idx, cnt, sbad, shigh;
    logic ga, ge, acc;
    logic [15:0] rd;

    initial begin
        // 1. Reset and idle
        dsel = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_outputs", {13'd0, s_ack, s_err, s_stall, s_dat}, 32'd0);
        end
        rst = 1'b0;
        cnt = 0;
        m_we = 1'b1; m_sel = 2'b11; m_adr = 16'd2; m_dat = 16'hDEAD;
        for (int i = 0; i < 6; i++) begin
            m_stb = i[0];
            tick();
            if (s_ack || s_err || s_stall) cnt++;
        end
        m_stb = 1'b0;
        chk("idle_stb_ignored", cnt, 32'd0);

        // 2. Single writes then reads
        for (int i = 1; i <= 10; i++) wr_chk("single_wr", 16'(i), 16'(100 + i), 2'b11);
        for (int i = 1; i <= 10; i++) rd_chk("single_rd", 16'(i), 16'(100 + i));

        // 3. Pipelined burst, one request per cycle
        burst(1'b1, 16'd11, 16'd211, 10);
        chk("b2b_wr_stall", nstall, 32'd0);
        chk("b2b_wr_acks", nack, 32'd10);
        chk("b2b_wr_consecutive", ack_last - ack_first, 32'd9);
        burst(1'b0, 16'd11, 16'd0, 10);
        chk("b2b_rd_stall", nstall, 32'd0);
        chk("b2b_rd_acks", nack, 32'd10);
        chk("b2b_rd_consecutive", ack_last - ack_first, 32'd9);
        for (int i = 0; i < 10 && i < rdq.size(); i++)
            chk("b2b_rd_data", {16'd0, rdq[i]}, 32'(211 + i));

        // 4. Back-pressure: latency 3, one outstanding
        m_cyc = 1'b0; tick(); dsel = 1;
        burst(1'b1, 16'd40, 16'h0A00, 4);
        chk("bp_wr_acks", nack, 32'd4);
        burst(1'b0, 16'd40, 16'd0, 4);
        chk("bp_rd_acks", nack, 32'd4);
        chk("bp_rd_errs", nerr, 32'd0);
        chk("bp_rd_stalls", nstall, 32'd6);
        chk("bp_rd_spacing", ack_last - ack_first, 32'd9);
        for (int i = 0; i < 4 && i < rdq.size(); i++)
            chk("bp_rd_data", {16'd0, rdq[i]}, 32'(16'h0A00 + i));

        // 5. Byte selects, boundary address and out-of-range
        m_cyc = 1'b0; tick(); dsel = 0;
        wr_chk("bs_full", 16'd5, 16'hFFFF, 2'b11);
        wr_chk("bs_low", 16'd5, 16'h1234, 2'b01);
        rd_chk("bs_rd", 16'd5, 16'hFF34);
        wr_chk("sel0_wr", 16'd6, 16'h9999, 2'b00);
        rd_chk("sel0_rd", 16'd6, 16'd106);
        wr_chk("top_wr", 16'd255, 16'hABCD, 2'b11);
        rd_chk("top_rd", 16'd255, 16'hABCD);
        single(1'b0, 16'd300, 16'd0, 2'b11, lat, ga, ge, rd);
        chk("oor_rd_lat", lat, 32'd2);
        chk("oor_rd_ackerr", {30'd0, ga, ge}, 32'd1);
        chk("oor_rd_dat_hold", {16'd0, rd}, 32'h0000ABCD);
        single(1'b1, 16'd256, 16'h5555, 2'b11, lat, ga, ge, rd);
        chk("oor_wr_ackerr", {30'd0, ga, ge}, 32'd1);

        // 6. Stall injection and abort
        m_cyc = 1'b0; tick(); dsel = 2;
        m_cyc = 1'b1; m_we = 1'b1; m_sel = 2'b11; m_stb = 1'b0;
        idx = 0; nack = 0; sbad = 0; shigh = 0;
        for (int it = 0; it < 7; it++) begin
            if (s_stall !== ((it % 4) == 3)) sbad++;
            if (s_stall) shigh++;
            acc = 1'b0;
            if (it >= 2) begin
                m_stb = 1'b1; m_adr = 16'(60 + idx); m_dat = 16'(16'h6000 + idx);
                acc = !s_stall;
            end
            tick();
            if (acc) idx++;
            if (s_ack) nack++;
        end
        chk("inj_stall_pattern", sbad, 32'd0);
        chk("inj_stall_count", shigh, 32'd1);
        chk("abort_acks_before_drop", nack, 32'd3);
        chk("abort_accepted", idx, 32'd4);
        m_cyc = 1'b0; m_stb = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_ack || s_err) cnt++;
        end
        chk("abort_no_resp", cnt, 32'd0);
        chk("abort_stall_clear", {31'd0, s_stall}, 32'd0);
        rd_chk("abort_committed", 16'd63, 16'h6003);
        rd_chk("abort_first", 16'd60, 16'h6000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
